// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry, the hard-wired zero register,
// and the write-port bundle used by the arbiter and the register file wrapper.
package rf_pkg;

    localparam int RF_AW       = 5;
    localparam int RF_DW       = 32;
    localparam int RF_NREGS    = 32;
    localparam int RF_ZERO_REG = 0;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr (wrapping mod NREQ) wins; returns one-hot grant and encoded index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            hit
);

    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hit && req[i] && ((int'(ptr) + k) % NREQ) == i) begin
                    hit      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin
// over NREQ units, registered output stage, and a pending-write hazard mask.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [IW-1:0]     rf_src,
    output logic [2**AW-1:0]  pending
);

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] grant;
    logic            hit;
    logic            hs;
    logic            we_q;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .hit   (hit)
    );

    assign req_ready = rst ? '0 : grant;
    assign hs        = hit && !rst;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_src   <= '0;
            rr_ptr   <= '0;
        end else begin
            we_q <= hs && (win_addr != AW'(RF_ZERO_REG));
            if (hs) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
                rf_src   <= win_idx;
                rr_ptr   <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
            end
        end
    end

    // Gating with rst drops a staged write in the same cycle reset arrives,
    // so the register file never commits it.
    assign rf_we = we_q && !rst;

    always_comb begin
        pending = '0;
        for (int r = 1; r < 2**AW; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_addr[i*AW +: AW] == AW'(r))
                    pending[r] = 1'b1;
            end
            if (rf_we && rf_waddr == AW'(r))
                pending[r] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=2) with a behavioural register
// file fed from rf_we/rf_waddr/rf_wdata.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [0:0]        rf_src;
    logic [2**AW-1:0]  pending;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] regs [2**AW];

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_src    (rf_src),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Behavioural register file; register 0 is hard-wired to zero.
    always @(posedge clk)
        if (rf_we && rf_waddr != '0) regs[rf_waddr] <= rf_wdata;

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]       = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        tick(); tick();
        vectors++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || rf_src !== 1'b0 ||
                req_ready !== 2'b00 || pending !== '0) begin
                errors++;
                $display("FAIL idle_%0d: got we=%b wa=%h wd=%h src=%b rdy=%b pend=%h want all zero",
                         c, rf_we, rf_waddr, rf_wdata, rf_src, req_ready, pending);
            end
        end
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
        vectors++;
        if (pending !== 32'h0000_0020) begin errors++; $display("FAIL single_pend: got %h want 00000020", pending); end
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || rf_src !== 1'b0) begin
            errors++;
            $display("FAIL single_out: got we=%b wa=%0d wd=%h src=%b want 1 5 deadbeef 0", rf_we, rf_waddr, rf_wdata, rf_src);
        end
        tick();
        vectors++;
        if (regs[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rf: got %h want deadbeef", regs[5]); end
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_hold: got we=%b wa=%0d wd=%h want 0 5 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_contention();
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 1'b1, 5'd1, 32'hA0A0_0000);
        set_req(1, 1'b1, 5'd2, 32'hB0B0_0000);
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            tick();
            vectors++;
            if (rf_we !== 1'b1 || rf_waddr !== ((k % 2 == 0) ? 5'd1 : 5'd2) || rf_src !== 1'((k % 2))) begin
                errors++; $display("FAIL rr_out_%0d: got we=%b wa=%0d src=%b", k, rf_we, rf_waddr, rf_src);
            end
        end
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_zero_reg();
        set_req(1, 1'b1, 5'd0, 32'h1234);
        #1;
        vectors++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_ready: got %b want 10", req_ready); end
        vectors++;
        if (pending !== '0) begin errors++; $display("FAIL zero_pend_req: got %h want 0", pending); end
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        vectors++;
        if (rf_we !== 1'b0 || pending !== '0) begin
            errors++; $display("FAIL zero_out: got we=%b pend=%h want 0 0", rf_we, pending);
        end
        tick();
        vectors++;
        if (regs[0] !== 32'h0) begin errors++; $display("FAIL zero_rf: got %h want 0", regs[0]); end
    endtask

    task automatic test_pending();
        // Winner 0 moves the pointer to 1 so requester 1 wins the next tie.
        set_req(0, 1'b1, 5'd10, 32'h10);
        tick();
        set_req(0, 1'b1, 5'd7, 32'h77);
        set_req(1, 1'b1, 5'd8, 32'h88);
        #1;
        vectors++;
        if (req_ready !== 2'b10 || pending[7] !== 1'b1) begin
            errors++; $display("FAIL pend_wait: got rdy=%b p7=%b want 10 1", req_ready, pending[7]);
        end
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        #1;
        vectors++;
        if (req_ready !== 2'b01 || pending[7] !== 1'b1 || rf_waddr !== 5'd8 || rf_we !== 1'b1) begin
            errors++; $display("FAIL pend_held: got rdy=%b p7=%b wa=%0d we=%b want 01 1 8 1", req_ready, pending[7], rf_waddr, rf_we);
        end
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || pending[7] !== 1'b1) begin
            errors++; $display("FAIL pend_staged: got we=%b wa=%0d p7=%b want 1 7 1", rf_we, rf_waddr, pending[7]);
        end
        tick();
        vectors++;
        if (rf_we !== 1'b0 || pending[7] !== 1'b0 || regs[7] !== 32'h77) begin
            errors++; $display("FAIL pend_clear: got we=%b p7=%b r7=%h want 0 0 77", rf_we, pending[7], regs[7]);
        end
    endtask

    task automatic test_reset_mid();
        // Pointer is 1 here; a lone req0 handshake leaves it at 1.
        set_req(0, 1'b1, 5'd3, 32'h3333);
        tick();
        set_req(0, 1'b1, 5'd12, 32'hC);
        set_req(1, 1'b1, 5'd13, 32'hD);
        rst = 1'b1;
        #1;
        vectors++;
        if (rf_we !== 1'b0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rstmid_gate: got we=%b rdy=%b want 0 00", rf_we, req_ready);
        end
        vectors++;
        if (pending !== 32'h0000_3000) begin errors++; $display("FAIL rstmid_pend: got %h want 00003000", pending); end
        tick();
        vectors++;
        if (rf_we !== 1'b0 || regs[3] !== 32'h0) begin
            errors++; $display("FAIL rstmid_drop: got we=%b r3=%h want 0 0", rf_we, regs[3]);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_tie: got %b want 01", req_ready); end
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd0, 32'h0);
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_src !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: got we=%b wa=%0d src=%b want 1 12 0", rf_we, rf_waddr, rf_src);
        end
        tick();
    endtask

    initial begin
        for (int r = 0; r < 2**AW; r++) regs[r] = '0;
        test_reset();
        test_single();
        test_contention();
        test_zero_reg();
        test_pending();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. Accepts register-write requests from up to NREQ execution units (ALU, load unit, multiplier, …) over valid/ready handshakes, selects one per cycle by round-robin, and drives the register file's we/waddr/wdata from a registered output stage. Also exports a pending-write mask so issue logic can stall on read-after-write hazards.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; handshake completes when valid && ready
- rf_we  out  1  to register file write enable
- rf_waddr  out  AW  to register file write address
- rf_wdata  out  DW  to register file write data
- rf_src  out  clog2(NREQ)  index of requester whose write is on rf_* (debug/trace)
- pending  out  2**AW  bit r set when a write to register r is requested or staged; bit 0 always 0

## Operation
- Round-robin pointer rr_ptr (clog2(NREQ) bits) names the highest-priority requester. The winner is the first i with req_valid[i] = 1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
- req_ready is combinational: exactly one bit high, at the winner, when any req_valid is high and rst = 0; otherwise all zero. req_ready never depends on req_ready.
- The output stage never stalls, since the register file always accepts. Every cycle it loads:
  - rf_we = (a handshake occurred) && (winner addr != 0)
  - rf_waddr = winner addr
  - rf_wdata = winner data
  - rf_src = winner index
- With no handshake, rf_we loads 0 and rf_waddr/rf_wdata/rf_src hold their previous values.
- On a handshake, rr_ptr loads (winner+1) mod NREQ. Without one, rr_ptr holds.
- Writes to register 0 are accepted (ready asserted) and discarded. rf_we stays 0 and the pending mask is unaffected.
- pending[r], r != 0 = (any i: req_valid[i] && req_addr_i == r) || (rf_we && rf_waddr == r). This is combinational from inputs plus the output stage.
- Requesters hold valid/addr/data stable until the handshake. The arbiter does not check this.
- Same address from two requesters: served in grant order. The later grant wins in the register file.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0, rr_ptr=0.
- During rst, req_ready = 0 and no handshake occurs. pending reflects req_valid only.
- Latency: a handshake in cycle N puts rf_we=1 in cycle N+1. The register file updates at the end of N+1, so a read returns the value in N+2.
- Throughput: one write per cycle sustained. Requester i waits at most NREQ-1 cycles when all requesters are continuously valid.
- rst asserted mid-stream: the write staged in the output stage is dropped (rf_we=0 the next cycle), and rr_ptr returns to 0. Requesters re-present after reset.
- rr_ptr wrap: NREQ-1 → 0. For non-power-of-two NREQ, the pointer never takes values ≥ NREQ.

## Structure
- Shared package rf_pkg holds:
  - RF_AW=5, RF_DW=32, RF_NREGS=32
  - RF_ZERO_REG=0
  - typedef rf_wr_t {we, addr, data}, also reused by the register file wrapper
- Sub-module rr_arbiter(NREQ): inputs req vector and pointer; outputs one-hot grant and encoded index; purely combinational. The top holds rr_ptr, the output stage and the pending logic.
- Target size: ~150–250 lines total.

## Test plan
1. Reset, then idle: rf_we=0, rf_waddr=0, rf_wdata=0, req_ready=00, pending=0 for 5 cycles.
2. Single requester:
   - Stimulus: req 0 presents addr=5, data=0xDEADBEEF for one cycle, with ready seen.
   - Response: next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, rf_src=0. The register file reads 0xDEADBEEF two cycles after the handshake.
3. Contention, NREQ=2:
   - Stimulus: both requesters valid continuously, req0 addr=1, req1 addr=2, starting from rr_ptr=0.
   - Response: grants alternate 0,1,0,1, and rf_waddr sequence is 1,2,1,2 one cycle later.
4. Zero register:
   - Stimulus: req1 writes addr=0, data=0x1234.
   - Response: req_ready[1]=1 and the handshake completes. Next cycle rf_we=0, pending[0]=0, and register 0 reads 0.
5. Pending mask:
   - Stimulus: req0 valid with addr=7 and held off by req1 winning.
   - Response: pending[7]=1 while waiting and for the cycle rf_we=1, rf_waddr=7; pending[7]=0 afterwards.
6. Reset mid-operation:
   - Stimulus: assert rst the cycle after a handshake to addr=3.
   - Response: rf_we=0 next cycle, register 3 unchanged, req_ready=00 during rst, rr_ptr=0 afterwards (req0 wins the first tie).
